// File: rtl/pipe_stage_pkg.sv
// Shared definitions for pipeline stage blocks: default payload widths and
// the occupancy state encoding of a two-entry skid register.
package pipe_stage_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_CTRL_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_stage_entry.sv
// One payload slot: a CTRL+DATA register with load enable and a synchronous
// clear that zeroes only the control bits.
module pipe_stage_entry #(
  parameter int DATA_WIDTH = 32,
  parameter int CTRL_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  input  logic                  load,
  input  logic [CTRL_WIDTH-1:0] d_ctrl,
  input  logic [DATA_WIDTH-1:0] d_data,
  output logic [CTRL_WIDTH-1:0] q_ctrl,
  output logic [DATA_WIDTH-1:0] q_data
);

  // Clear wins over load; data is left in place so the output bus stays quiet.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ctrl <= '0;
      q_data <= '0;
    end else if (clr) begin
      q_ctrl <= '0;
    end else if (load) begin
      q_ctrl <= d_ctrl;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_skid_register.sv
// Two-entry skid register between pipeline stages. IN_READY comes only from
// registered occupancy and BUSYWAIT, breaking the ready path from downstream.
module pipe_skid_register
  import pipe_stage_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CTRL_WIDTH = DEFAULT_CTRL_WIDTH
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  BUSYWAIT,
  input  logic                  FLUSH,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic [CTRL_WIDTH-1:0] IN_CTRL,
  input  logic [DATA_WIDTH-1:0] IN_DATA,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [CTRL_WIDTH-1:0] OUT_CTRL,
  output logic [DATA_WIDTH-1:0] OUT_DATA,
  output pipe_state_e           state_dbg
);

  // Handshake: a payload moves on a side only when valid and ready are both
  // high in the same cycle and BUSYWAIT is low; FLUSH overrides everything.

  pipe_state_e state, state_next;
  logic        out_valid_q;
  logic        accept, emit;
  logic        main_load, main_from_skid, skid_load;

  logic [CTRL_WIDTH-1:0] main_ctrl, skid_ctrl, main_d_ctrl;
  logic [DATA_WIDTH-1:0] main_data, skid_data, main_d_data;

  assign IN_READY  = (state != ST_FULL) & ~BUSYWAIT;
  assign accept    = IN_VALID & IN_READY & ~BUSYWAIT;
  assign emit      = out_valid_q & OUT_READY & ~BUSYWAIT;
  assign state_dbg = state;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_EMPTY;
      out_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      out_valid_q <= (state_next != ST_EMPTY);
    end
  end

  always_comb begin
    state_next     = state;
    main_load      = 1'b0;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    if (FLUSH) begin
      state_next = ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (accept) begin
            state_next = ST_ONE;
            main_load  = 1'b1;
          end
        end
        ST_ONE: begin
          if (accept && !emit) begin
            state_next = ST_FULL;
            skid_load  = 1'b1;
          end else if (emit && !accept) begin
            state_next = ST_EMPTY;
          end else if (accept && emit) begin
            main_load = 1'b1;
          end
        end
        ST_FULL: begin
          if (emit) begin
            state_next     = ST_ONE;
            main_load      = 1'b1;
            main_from_skid = 1'b1;
          end
        end
        default: state_next = ST_EMPTY;
      endcase
    end
  end

  assign main_d_ctrl = main_from_skid ? skid_ctrl : IN_CTRL;
  assign main_d_data = main_from_skid ? skid_data : IN_DATA;

  pipe_stage_entry #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_main (
    .clk    (CLK),
    .rst_n  (RESET),
    .clr    (FLUSH),
    .load   (main_load),
    .d_ctrl (main_d_ctrl),
    .d_data (main_d_data),
    .q_ctrl (main_ctrl),
    .q_data (main_data)
  );

  pipe_stage_entry #(.DATA_WIDTH(DATA_WIDTH), .CTRL_WIDTH(CTRL_WIDTH)) u_skid (
    .clk    (CLK),
    .rst_n  (RESET),
    .clr    (FLUSH),
    .load   (skid_load),
    .d_ctrl (IN_CTRL),
    .d_data (IN_DATA),
    .q_ctrl (skid_ctrl),
    .q_data (skid_data)
  );

  assign OUT_VALID = out_valid_q;
  assign OUT_CTRL  = out_valid_q ? main_ctrl : '0;
  assign OUT_DATA  = main_data;

endmodule

// File: tb/tb_pipe_skid_register.sv
// Bench for pipe_skid_register: directed vector table, hand-written reset
// sequences and random traffic against a queue-based reference model.
module tb_pipe_skid_register;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        BUSYWAIT, FLUSH, IN_VALID, OUT_READY;
  logic        IN_READY, OUT_VALID;
  logic [15:0] IN_CTRL, OUT_CTRL;
  logic [31:0] IN_DATA, OUT_DATA;
  logic [1:0]  state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_skid_register #(.DATA_WIDTH(32), .CTRL_WIDTH(16)) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .BUSYWAIT  (BUSYWAIT),
    .FLUSH     (FLUSH),
    .IN_VALID  (IN_VALID),
    .IN_READY  (IN_READY),
    .IN_CTRL   (IN_CTRL),
    .IN_DATA   (IN_DATA),
    .OUT_VALID (OUT_VALID),
    .OUT_READY (OUT_READY),
    .OUT_CTRL  (OUT_CTRL),
    .OUT_DATA  (OUT_DATA),
    .state_dbg (state_dbg)
  );

  always #5 CLK = ~CLK;

  // Reference model: the held payloads in order ({ctrl, data}), capacity two,
  // plus the last data value that reached the output position.
  logic [47:0] exp_q[$];
  logic [31:0] m_main;
  logic        m_bw;

  typedef struct {
    logic        iv, bw, fl, ordy;
    logic [15:0] ctrl;
    logic [31:0] data;
    logic        e_valid, e_ready;
    logic [15:0] e_ctrl;
    logic [31:0] e_data;
    logic [1:0]  e_state;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_main = '0;
  endtask

  task automatic model_step(input logic iv, bw, fl, ordy, input logic [15:0] ctrl,
                            input logic [31:0] data);
    int  n;
    bit  acc, emt;
    n   = exp_q.size();
    acc = iv && (n < 2) && !bw;
    emt = (n > 0) && ordy && !bw;
    if (fl) begin
      exp_q.delete();
    end else begin
      if (emt) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({ctrl, data});
    end
    if (exp_q.size() > 0) m_main = exp_q[0][31:0];
    m_bw = bw;
  endtask

  task automatic check_model(input string tag);
    logic        v;
    logic [15:0] c;
    v = (exp_q.size() > 0);
    c = v ? exp_q[0][47:32] : 16'h0;
    chk({tag, "_out_valid"}, {31'b0, OUT_VALID}, {31'b0, v});
    chk({tag, "_out_ctrl"},  {16'b0, OUT_CTRL},  {16'b0, c});
    chk({tag, "_out_data"},  OUT_DATA, m_main);
    chk({tag, "_in_ready"},  {31'b0, IN_READY}, {31'b0, (exp_q.size() < 2) && !m_bw});
    chk({tag, "_state"},     {30'b0, state_dbg}, exp_q.size());
  endtask

  // Called with the time just after a falling edge; returns at the next one.
  task automatic cycle(input logic iv, bw, fl, ordy, input logic [15:0] ctrl,
                       input logic [31:0] data, input string tag);
    IN_VALID = iv; BUSYWAIT = bw; FLUSH = fl; OUT_READY = ordy;
    IN_CTRL = ctrl; IN_DATA = data;
    model_step(iv, bw, fl, ordy, ctrl, data);
    @(posedge CLK);
    @(negedge CLK);
    check_model(tag);
  endtask

  function automatic vec_t mk(input logic iv, bw, fl, ordy, input logic [15:0] ctrl,
                              input logic [31:0] data, input logic ev, er,
                              input logic [15:0] ec, input logic [31:0] ed,
                              input logic [1:0] es);
    vec_t v;
    v.iv = iv; v.bw = bw; v.fl = fl; v.ordy = ordy; v.ctrl = ctrl; v.data = data;
    v.e_valid = ev; v.e_ready = er; v.e_ctrl = ec; v.e_data = ed; v.e_state = es;
    return v;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Expected values are the outputs after the edge, inputs still applied.
    //                iv bw fl or ctrl      data    | val rdy ctrl     data  st
    vecs.push_back(mk(1, 0, 0, 1, 16'h00A5, 32'd120, 1, 1, 16'h00A5, 32'd120, 2'd1));
    vecs.push_back(mk(1, 0, 0, 1, 16'h00A5, 32'd124, 1, 1, 16'h00A5, 32'd124, 2'd1));
    vecs.push_back(mk(1, 0, 0, 1, 16'h00A5, 32'd128, 1, 1, 16'h00A5, 32'd128, 2'd1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 32'd0,   0, 1, 16'h0000, 32'd128, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0011, 32'd550, 1, 1, 16'h0011, 32'd550, 2'd1));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0022, 32'd890, 1, 0, 16'h0011, 32'd550, 2'd2));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0033, 32'd999, 1, 0, 16'h0011, 32'd550, 2'd2));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 32'd0,   1, 1, 16'h0022, 32'd890, 2'd1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 32'd0,   0, 1, 16'h0000, 32'd890, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0044, 32'd345, 1, 1, 16'h0044, 32'd345, 2'd1));
    vecs.push_back(mk(1, 1, 0, 1, 16'h0055, 32'd777, 1, 0, 16'h0044, 32'd345, 2'd1));
    vecs.push_back(mk(1, 1, 0, 1, 16'h0055, 32'd777, 1, 0, 16'h0044, 32'd345, 2'd1));
    vecs.push_back(mk(1, 1, 0, 1, 16'h0055, 32'd777, 1, 0, 16'h0044, 32'd345, 2'd1));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 32'd0,   0, 1, 16'h0000, 32'd345, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0066, 32'd600, 1, 1, 16'h0066, 32'd600, 2'd1));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0067, 32'd601, 1, 0, 16'h0066, 32'd600, 2'd2));
    vecs.push_back(mk(1, 1, 1, 1, 16'h0068, 32'd602, 0, 0, 16'h0000, 32'd600, 2'd0));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 32'd0,   0, 1, 16'h0000, 32'd600, 2'd0));
    vecs.push_back(mk(1, 0, 0, 0, 16'h0070, 32'd700, 1, 1, 16'h0070, 32'd700, 2'd1));
    vecs.push_back(mk(1, 0, 1, 0, 16'h0071, 32'd701, 0, 1, 16'h0000, 32'd700, 2'd0));
    vecs.push_back(mk(0, 0, 0, 1, 16'h0000, 32'd0,   0, 1, 16'h0000, 32'd700, 2'd0));

    // Reset held for two cycles with a payload offered.
    RESET = 1'b0; BUSYWAIT = 1'b0; FLUSH = 1'b0; IN_VALID = 1'b1; OUT_READY = 1'b1;
    IN_CTRL = 16'hBEEF; IN_DATA = 32'h1234_5678;
    model_reset(); m_bw = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("rst_out_ctrl",  {16'b0, OUT_CTRL},  32'd0);
    chk("rst_out_data",  OUT_DATA, 32'd0);
    chk("rst_state",     {30'b0, state_dbg}, 32'd0);
    IN_VALID = 1'b0;
    RESET    = 1'b1;
    #1;
    chk("rst_in_ready", {31'b0, IN_READY}, 32'd1);

    for (int i = 0; i < vecs.size(); i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      cycle(vecs[i].iv, vecs[i].bw, vecs[i].fl, vecs[i].ordy, vecs[i].ctrl, vecs[i].data, t);
      chk({t, "_exp_valid"}, {31'b0, OUT_VALID}, {31'b0, vecs[i].e_valid});
      chk({t, "_exp_ready"}, {31'b0, IN_READY},  {31'b0, vecs[i].e_ready});
      chk({t, "_exp_ctrl"},  {16'b0, OUT_CTRL},  {16'b0, vecs[i].e_ctrl});
      chk({t, "_exp_data"},  OUT_DATA, vecs[i].e_data);
      chk({t, "_exp_state"}, {30'b0, state_dbg}, {30'b0, vecs[i].e_state});
    end

    // Random traffic, including occasional stalls and flushes.
    for (int i = 0; i < 600; i++) begin
      cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0),
            1'($urandom_range(0, 24) == 0), 1'($urandom_range(0, 2) != 0),
            16'($urandom_range(0, 65535)), $urandom(), "rnd");
    end

    // Reset asserted between clock edges while holding a payload.
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 16'h0, 32'h0, "pre_flush");
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 16'h1234, 32'hDEAD_BEEF, "pre_load");
    IN_VALID = 1'b0;
    #2;
    RESET = 1'b0;
    #1;
    chk("async_out_valid", {31'b0, OUT_VALID}, 32'd0);
    chk("async_out_ctrl",  {16'b0, OUT_CTRL},  32'd0);
    chk("async_out_data",  OUT_DATA, 32'd0);
    chk("async_state",     {30'b0, state_dbg}, 32'd0);
    @(negedge CLK);
    RESET = 1'b1;
    model_reset();
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 16'h0, 32'h0, "post_async");
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 16'h0ABC, 32'd42, "post_async_load");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_register.md
PIPE_SKID_REGISTER -- requirements
Module: pipe_skid_register

Interface
REQ-001 SHALL provide parameter DATA_WIDTH, default 32, width of the datapath payload in bits.
REQ-002 SHALL provide parameter CTRL_WIDTH, default 16, width of the control payload, zeroed on bubbles.
REQ-003 SHALL have one clock; reset is asynchronous and active-low.
REQ-004 SHALL have port CLK, input, 1, rising-edge clock.
REQ-005 SHALL have port RESET, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port BUSYWAIT, input, 1, global pipeline freeze; no transfer occurs on either side.
REQ-007 SHALL have port FLUSH, input, 1, synchronous discard of all held entries.
REQ-008 SHALL have port IN_VALID, input, 1, upstream offers a payload.
REQ-009 SHALL have port IN_READY, output, 1, block can accept a payload.
REQ-010 SHALL have port IN_CTRL, input, CTRL_WIDTH, upstream control bits.
REQ-011 SHALL have port IN_DATA, input, DATA_WIDTH, upstream datapath bits.
REQ-012 SHALL have port OUT_VALID, output, 1, payload present at the outputs.
REQ-013 SHALL have port OUT_READY, input, 1, downstream takes the payload.
REQ-014 SHALL have port OUT_CTRL, output, CTRL_WIDTH, held control bits, or all-zero bubble.
REQ-015 SHALL have port OUT_DATA, output, DATA_WIDTH, held datapath bits.

Function
REQ-016 SHALL define accept = IN_VALID & IN_READY & !BUSYWAIT.
REQ-017 SHALL define emit = OUT_VALID & OUT_READY & !BUSYWAIT.
REQ-018 SHALL hold a main entry and a skid entry, each storing CTRL and DATA.
REQ-019 SHALL implement states EMPTY (no entries), ONE (main only) and FULL (main and skid).
REQ-020 SHALL drive OUT_VALID from a register: 0 in EMPTY, 1 in ONE and FULL.
REQ-021 SHALL drive IN_READY = (state != FULL) & !BUSYWAIT.
REQ-022 SHALL make IN_READY depend on no other input, in particular not on OUT_READY.
REQ-023 SHALL, in EMPTY, move to ONE on accept, with main loaded from the inputs.
REQ-024 SHALL, in ONE with accept and no emit, move to FULL, with skid loaded from the inputs.
REQ-025 SHALL, in ONE with emit and no accept, move to EMPTY.
REQ-026 SHALL, in ONE with both accept and emit, stay in ONE, with main loaded from the inputs.
REQ-027 SHALL, in FULL on emit, move to ONE, with main loaded from skid.
REQ-028 SHALL hold state and all entries whenever BUSYWAIT=1, regardless of IN_VALID and OUT_READY.
REQ-029 SHALL, on FLUSH=1 at a clock edge, go to EMPTY and zero both CTRL entries.
REQ-030 SHALL give FLUSH priority over BUSYWAIT, accept and emit, discarding any same-cycle accept.
REQ-031 SHALL drive OUT_CTRL as all-zero whenever OUT_VALID=0.
REQ-032 SHALL drive OUT_DATA from main at all times, held when empty.
REQ-033 SHALL give 1-cycle latency: an accept in EMPTY gives OUT_VALID=1 after the next rising edge.
REQ-034 SHALL sustain full throughput of one transfer per cycle in ONE while OUT_READY=1.
REQ-035 SHALL never drop, duplicate or reorder payloads; order is main before skid.

Reset
REQ-036 SHALL, while RESET=0, force state EMPTY, all entries zero, OUT_VALID=0 and OUT_CTRL=0, with OUT_DATA=0.
REQ-037 SHALL, after reset, present IN_READY=1 whenever BUSYWAIT=0.
REQ-038 SHALL, on reset asserted mid-transfer, lose held entries immediately and without waiting for a clock edge.

Structure
REQ-039 SHALL place the state typedef (EMPTY/ONE/FULL, 2-bit encoding) in shared package pipe_stage_pkg.
REQ-040 SHALL place default width constants in shared package pipe_stage_pkg.
REQ-041 SHALL use one sub-module, pipe_stage_entry: a reset, load-enabled CTRL+DATA register, instantiated twice.

Verification
REQ-042 SHALL verify reset: RESET=0 for 2 cycles with IN_VALID=1 -> OUT_VALID=0, OUT_CTRL=0, OUT_DATA=0; IN_READY=1 after release.
REQ-043 SHALL verify latency and throughput: CTRL=8'hA5, DATA=32'd120, OUT_READY=1, then 3 back-to-back payloads (32'd120, 32'd124, 32'd128) -> OUT_DATA 120, 124, 128 on consecutive cycles after a 1-cycle latency.
REQ-044 SHALL verify backpressure: OUT_READY=0 while sending 32'd550 then 32'd890 -> FULL, IN_READY=0; then OUT_READY=1 -> 550 then 890 emitted in order, IN_READY=1 again.
REQ-045 SHALL verify stall: BUSYWAIT=1 for 3 cycles while holding 32'd345 with IN_VALID=1 and OUT_READY=1 -> outputs unchanged, IN_READY=0, no state change.
REQ-046 SHALL verify flush: FLUSH=1 in FULL with a same-cycle IN_VALID=1 and BUSYWAIT=1 -> next cycle EMPTY, OUT_VALID=0, OUT_CTRL=0, and the flushed payload never appears.
